debug_tx_framer: RTL and testbench
==================================

# debug_tx_framer

Upstream feeder for the debugger unit's UART transmitter. Accepts whole debug words (register, PC or memory values) into a small FIFO and serializes each word into `LEN_DATA`-bit bytes, least significant byte first. For each byte it drives the transmitter's byte input and a one-cycle `tx_start` pulse, then waits for the transmitter's `tx_done` pulse before sending the next byte. The debug controller can queue several words without tracking UART progress.

## Interface

Parameters:
- `LEN_DATA`, 8: byte width; equals the transmitter's data width.
- `WORD_WIDTH`, 32: width of a queued word. Must be an integer multiple of `LEN_DATA`; elaboration error otherwise.
- `FIFO_DEPTH`, 4: number of queued words. Power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  push `wr_data` into FIFO this cycle.
- `wr_data`  in  `WORD_WIDTH`  word to transmit.
- `full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `empty`  out  1  FIFO holds no words.
- `busy`  out  1  FSM not in IDLE (a word is being sent).
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_done`  in  1  one-cycle pulse from transmitter: stop bit finished.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  `LEN_DATA`  byte to transmit; stable from `tx_start` until `tx_done`.

## Operation

- `BYTES = WORD_WIDTH / LEN_DATA`. Byte counter width is `$clog2(BYTES)`, minimum 1.
- FIFO count width is `$clog2(FIFO_DEPTH)+1`. Read and write pointers wrap modulo `FIFO_DEPTH`.
- Write rules:
  - `wr_en && !full`: word accepted.
  - `wr_en && full` with no pop in the same cycle: word dropped, `overflow` set.
  - `wr_en && full` with a pop in the same cycle: word accepted, count unchanged.
- FSM states:
  - **IDLE**: if `!empty`, pop the head word into shift register `word_q`, set byte counter to `BYTES-1`, go to SEND. Otherwise stay.
  - **SEND**: `tx_start=1` for exactly this cycle; go to WAIT.
  - **WAIT**: hold until `tx_done`.
    - On `tx_done` with counter ≠ 0: `word_q >>= LEN_DATA`, decrement the counter, go to SEND.
    - On `tx_done` with counter = 0: go to IDLE.
- `tx_data = word_q[LEN_DATA-1:0]`, registered.
- `tx_start` is decoded from state (`state==SEND`).
- `busy = (state != IDLE)`.
- `tx_done` received in IDLE or SEND is ignored.
- Reset (any time, including mid-word):
  - State returns to IDLE; FIFO pointers and count are cleared, so queued contents are discarded.
  - Output values after reset: `word_q`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `full`=0, `empty`=1, `overflow`=0.
  - `overflow` clears only on reset.

## Timing

- Write to an empty FIFO with FSM in IDLE:
  - `wr_en` high in cycle k;
  - `empty`=0 in cycle k+1, and IDLE pops at the end of k+1;
  - `tx_start`=1 in cycle k+2.
- Between bytes of one word: `tx_done` in cycle j gives `tx_start` in cycle j+1. The transmitter is back in idle in j+1, so it latches the byte.
- Between words: `tx_done` for the last byte in cycle j, IDLE in j+1, `tx_start` for the next word's byte 0 in j+2 if the FIFO is non-empty.
- `full` and `empty` are derived from the registered count and reflect the previous edge.
- Throughput is bounded by the UART. The framer adds 1 idle cycle between bytes and 2 between words.

## Structure

- Shared package `debug_unit_pkg`:
  - FSM state encoding (IDLE, SEND, WAIT; 2 bits);
  - the `BYTES` computation;
  - the `LEN_DATA` default shared with the transmitter.
- Sub-module `sync_fifo`: parameterized width/depth; push/pop/full/empty/count; same clock and reset.
- The framer instantiates one `sync_fifo` and contains the FSM, shift register and byte counter.

## Test plan

- Single word `0xA1B2C3D4`, `tx_done` modeled 10 cycles after each `tx_start` → four `tx_start` pulses with `tx_data` = `0xD4`, `0xC3`, `0xB2`, `0xA1`. `busy` falls the cycle after the 4th `tx_done`.
- Latency: `wr_en` in cycle 5 on an idle block → `tx_start` in cycle 7; next `tx_start` exactly 1 cycle after each `tx_done`.
- Fill: five writes (`0x1`..`0x5`) in consecutive cycles while the FSM is blocked waiting for `tx_done` → `full`=1 after 4 stored words, 5th dropped, `overflow`=1. Output bytes show words 1..4 only.
- Write on `full` in the same cycle as an IDLE pop → word accepted, `overflow` stays 0, `full` remains 1.
- Spurious `tx_done` in IDLE and SEND → no state change, no extra `tx_start`, no byte skipped.
- `rst` low mid-word (after byte 1 of `0xDEADBEEF`, 2 words queued) → all outputs at reset values. After release, no `tx_start` until a new write.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: state encoding and sizing helpers shared by the debugger unit
package debug_unit_pkg;

    localparam int LEN_DATA_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

    function automatic int bytes_per_word(input int word_width, input int len_data);
        return word_width / len_data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken only when a pop frees the slot
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/debug_tx_framer.sv
// debug_tx_framer: queues debug words and feeds them LSB-byte-first to the UART transmitter
module debug_tx_framer
    import debug_unit_pkg::*;
#(
    parameter int LEN_DATA   = LEN_DATA_DEFAULT,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [LEN_DATA-1:0]   tx_data
);

    localparam int BYTES = bytes_per_word(WORD_WIDTH, LEN_DATA);
    localparam int CW    = BYTES > 1 ? $clog2(BYTES) : 1;

    if (WORD_WIDTH < LEN_DATA || WORD_WIDTH % LEN_DATA != 0) begin : g_bad_width
        $error("debug_tx_framer WORD_WIDTH must be a multiple of LEN_DATA");
    end

    tx_state_e             state;
    logic [WORD_WIDTH-1:0] word_q, head;
    logic [CW-1:0]         cnt;
    logic                  pop;

    assign pop      = state == IDLE && !empty;
    assign tx_start = state == SEND;
    assign busy     = state != IDLE;
    assign tx_data  = word_q[LEN_DATA-1:0];

    sync_fifo #(
        .WIDTH(WORD_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(wr_en),
        .pop(pop),
        .wr_data(wr_data),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );

    // tx_done outside WAIT belongs to no byte of ours and is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            word_q <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    word_q <= head;
                    cnt    <= CW'(BYTES - 1);
                    state  <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: if (tx_done) begin
                    if (cnt != '0) begin
                        word_q <= word_q >> LEN_DATA;
                        cnt    <= cnt - CW'(1);
                        state  <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overflow <= 1'b0;
        else if (wr_en && full && !pop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_debug_tx_framer.sv
// tb_debug_tx_framer: directed checks of byte order, timing, FIFO limits and reset
module tb_debug_tx_framer;

    logic        clk, rst, wr_en, tx_done;
    logic [31:0] wr_data;
    logic        full, empty, busy, overflow, tx_start;
    logic [7:0]  tx_data;
    int          n_chk, n_fail;

    debug_tx_framer #(.LEN_DATA(8), .WORD_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .busy(busy),
        .overflow(overflow),
        .tx_done(tx_done),
        .tx_start(tx_start),
        .tx_data(tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_chk(input logic [7:0] b, input logic spur);
        chk("tx_start_on", 32'(tx_start), 32'd1);
        chk("tx_data", 32'(tx_data), 32'(b));
        chk("busy_send", 32'(busy), 32'd1);
        tx_done = spur;
        tick(1);
        tx_done = 1'b0;
        chk("tx_start_pulse", 32'(tx_start), 32'd0);
    endtask

    task automatic finish(input int n, input logic last, input logic [7:0] b);
        tick(n);
        chk("tx_data_hold", 32'(tx_data), 32'(b));
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("busy_after_done", 32'(busy), 32'(!last));
        chk("tx_start_after_done", 32'(tx_start), 32'(!last));
    endtask

    task automatic word(input logic [31:0] d, input int from, input int spur);
        for (int i = from; i < 4; i++) begin
            start_chk(d[8*i+:8], i == spur);
            finish(9, i == 3, d[8*i+:8]);
        end
    endtask

    task automatic write(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        tx_done = 1'b0;
        tick(2);
        reset_outputs("reset");
        rst = 1'b1;
        tick(2);

        // stray tx_done while idle and empty
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(1);
        chk("idle_spur_busy", 32'(busy), 32'd0);
        chk("idle_spur_start", 32'(tx_start), 32'd0);

        // latency k -> k+2, byte order, stray tx_done during SEND of byte 1
        write(32'hA1B2C3D4);
        chk("lat_empty", 32'(empty), 32'd0);
        chk("lat_start_early", 32'(tx_start), 32'd0);
        tick(1);
        word(32'hA1B2C3D4, 0, 1);
        tick(2);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // fill while blocked in WAIT: 5th write dropped
        write(32'h11223344);
        tick(1);
        start_chk(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 32'(i + 1);
            chk("fill_full", 32'(full), 32'(i == 4));
            tick(1);
        end
        wr_en = 1'b0;
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_full_hold", 32'(full), 32'd1);
        finish(4, 1'b0, 8'h44);
        word(32'h11223344, 1, -1);
        for (int w = 1; w <= 4; w++) begin
            tick(1);
            word(32'(w), 0, -1);
        end
        tick(3);
        chk("fill_no_5th", 32'(tx_start), 32'd0);
        chk("fill_drained", 32'(empty), 32'd1);
        chk("fill_ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-word with two words queued
        wr_en = 1'b1;
        wr_data = 32'hDEADBEEF;
        tick(1);
        wr_data = 32'h0BADF00D;
        tick(1);
        wr_data = 32'h12345678;
        start_chk(8'hEF, 1'b0);
        wr_en = 1'b0;
        finish(8, 1'b0, 8'hEF);
        start_chk(8'hBE, 1'b0);
        tick(3);
        rst = 1'b0;
        #1;
        reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        tick(5);
        chk("post_rst_start", 32'(tx_start), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        // write on full in the same cycle as the IDLE pop
        write(32'hCAFEF00D);
        tick(1);
        start_chk(8'h0D, 1'b0);
        for (int i = 1; i <= 4; i++) write(32'h100 + 32'(i));
        chk("pop_full_before", 32'(full), 32'd1);
        finish(5, 1'b0, 8'h0D);
        word(32'hCAFEF00D, 1, -1);
        chk("pop_full_idle", 32'(full), 32'd1);
        write(32'h105);
        chk("pop_full_kept", 32'(full), 32'd1);
        chk("pop_no_overflow", 32'(overflow), 32'd0);
        word(32'h101, 0, -1);
        for (int w = 2; w <= 5; w++) begin
            tick(1);
            word(32'h100 + 32'(w), 0, -1);
        end
        tick(2);
        chk("pop_drained", 32'(empty), 32'd1);
        chk("pop_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
